// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with flush, bubble/hold handling,
// saturating performance counters and a sticky illegal-stall detector.
module pipe_stage_reg #(
   parameter int unsigned            DATA_W    = 32,
   parameter int unsigned            STALL_W   = 6,
   parameter int unsigned            STAGE     = 2,
   parameter logic [DATA_W-1:0]      NOP_VALUE = {DATA_W{1'b0}},
   parameter int unsigned            CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   input  logic               cnt_clr,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt,
   output logic               stall_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Counters stick at all-ones rather than wrapping; clear takes precedence.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic ev,
                                                 input logic clr);
      logic [CNT_W-1:0] res;
      if (clr) begin
         res = CNT_ZERO;
      end else if (ev && (cur != CNT_MAX)) begin
         res = cur + CNT_W'(1);
      end else begin
         res = cur;
      end
      return res;
   endfunction

   logic [DATA_W-1:0] data_r;
   logic              valid_r;
   logic [CNT_W-1:0]  hold_cnt_r;
   logic [CNT_W-1:0]  bubble_cnt_r;
   logic [CNT_W-1:0]  flush_cnt_r;
   logic              err_r;

   logic              up_s;
   logic              dn_s;
   logic [DATA_W-1:0] data_nxt_s;
   logic              valid_nxt_s;
   logic              hold_ev_s;
   logic              bubble_ev_s;
   logic              flush_ev_s;
   logic              illegal_ev_s;

   assign up_s = stall[STAGE];
   assign dn_s = stall[STAGE+1];

   // Next payload/valid and event decode; flush overrides every stall pattern.
   always_comb begin
      data_nxt_s   = data_r;
      valid_nxt_s  = valid_r;
      hold_ev_s    = 1'b0;
      bubble_ev_s  = 1'b0;
      flush_ev_s   = 1'b0;
      illegal_ev_s = 1'b0;
      if (flush) begin
         data_nxt_s  = NOP_VALUE;
         valid_nxt_s = 1'b0;
         flush_ev_s  = valid_r;
      end else begin
         case ({up_s, dn_s})
            2'b10: begin
               data_nxt_s  = NOP_VALUE;
               valid_nxt_s = 1'b0;
               bubble_ev_s = 1'b1;
            end
            2'b11: begin
               hold_ev_s = 1'b1;
            end
            2'b00: begin
               data_nxt_s  = in_data;
               valid_nxt_s = in_valid;
            end
            2'b01: begin
               // Downstream stalled while upstream runs: hold, but flag it.
               illegal_ev_s = 1'b1;
            end
            default: begin
               data_nxt_s  = data_r;
               valid_nxt_s = valid_r;
            end
         endcase
      end
   end

   // State register: data path, counters and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r       <= NOP_VALUE;
         valid_r      <= 1'b0;
         hold_cnt_r   <= CNT_ZERO;
         bubble_cnt_r <= CNT_ZERO;
         flush_cnt_r  <= CNT_ZERO;
         err_r        <= 1'b0;
      end else begin
         data_r       <= data_nxt_s;
         valid_r      <= valid_nxt_s;
         hold_cnt_r   <= cnt_next(hold_cnt_r,   hold_ev_s,   cnt_clr);
         bubble_cnt_r <= cnt_next(bubble_cnt_r, bubble_ev_s, cnt_clr);
         flush_cnt_r  <= cnt_next(flush_cnt_r,  flush_ev_s,  cnt_clr);
         err_r        <= cnt_clr ? 1'b0 : (err_r | illegal_ev_s);
      end
   end

   assign out_data   = data_r;
   assign out_valid  = valid_r;
   assign hold_cnt   = hold_cnt_r;
   assign bubble_cnt = bubble_cnt_r;
   assign flush_cnt  = flush_cnt_r;
   assign stall_err  = err_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a reference model pushes expected state
// into a scoreboard queue at each drive and the post-edge sample pops it.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [31:0] data;
      logic        valid;
      logic [15:0] hold;
      logic [15:0] bubble;
      logic [15:0] flsh;
      logic        err;
      logic [2:0]  hold3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] in_data;
   logic        in_valid;
   logic        cnt_clr;

   logic [31:0] out_data;
   logic        out_valid;
   logic [15:0] hold_cnt, bubble_cnt, flush_cnt;
   logic        stall_err;

   logic [31:0] s_out_data;
   logic        s_out_valid;
   logic [2:0]  s_hold_cnt, s_bubble_cnt, s_flush_cnt;
   logic        s_stall_err;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   exp_t m;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .cnt_clr(cnt_clr), .out_data(out_data),
      .out_valid(out_valid), .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt),
      .flush_cnt(flush_cnt), .stall_err(stall_err));

   pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(2), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .cnt_clr(cnt_clr), .out_data(s_out_data),
      .out_valid(s_out_valid), .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt),
      .flush_cnt(s_flush_cnt), .stall_err(s_stall_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] c, input logic ev, input logic clr);
      if (clr) return 16'd0;
      if (ev && c != 16'hFFFF) return c + 16'd1;
      return c;
   endfunction

   function automatic logic [2:0] sat3(input logic [2:0] c, input logic ev, input logic clr);
      if (clr) return 3'd0;
      if (ev && c != 3'd7) return c + 3'd1;
      return c;
   endfunction

   task automatic step(input string tag, input logic [5:0] st, input logic fl,
                       input logic [31:0] d, input logic v, input logic clr, input logic r);
      logic up, dn, he, be, fe, ie;
      exp_t e;
      stall = st; flush = fl; in_data = d; in_valid = v; cnt_clr = clr; rst = r;
      up = st[2]; dn = st[3];
      he = !fl && up && dn;
      be = !fl && up && !dn;
      fe = fl && m.valid;
      ie = !fl && !up && dn;
      if (r) begin
         m = '0;
      end else begin
         if (fl || be) begin
            m.data = 32'd0; m.valid = 1'b0;
         end else if (!up && !dn) begin
            m.data = d; m.valid = v;
         end
         m.hold   = sat16(m.hold, he, clr);
         m.bubble = sat16(m.bubble, be, clr);
         m.flsh   = sat16(m.flsh, fe, clr);
         m.hold3  = sat3(m.hold3, he, clr);
         m.err    = clr ? 1'b0 : (m.err | ie);
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({tag, ".data"},   out_data,            e.data);
      chk({tag, ".valid"},  {31'd0, out_valid},  {31'd0, e.valid});
      chk({tag, ".hold"},   {16'd0, hold_cnt},   {16'd0, e.hold});
      chk({tag, ".bubble"}, {16'd0, bubble_cnt}, {16'd0, e.bubble});
      chk({tag, ".flush"},  {16'd0, flush_cnt},  {16'd0, e.flsh});
      chk({tag, ".err"},    {31'd0, stall_err},  {31'd0, e.err});
      chk({tag, ".hold3"},  {29'd0, s_hold_cnt}, {29'd0, e.hold3});
   endtask

   initial begin
      m = '0;
      // reset with garbage on the input
      step("rst",    6'b000000, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
      chk("rst_data_zero", out_data, 32'd0);
      // advance then hold for three cycles, then release
      step("load11", 6'b000000, 1'b0, 32'h11, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("hold", 6'b001100, 1'b0, 32'h99, 1'b1, 1'b0, 1'b0);
      chk("hold_cnt_3", {16'd0, hold_cnt}, 32'd3);
      chk("hold_data", out_data, 32'h11);
      step("rel22",  6'b000000, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0);
      chk("release_data", out_data, 32'h22);
      // two bubbles
      for (int i = 0; i < 2; i++) step("bubble", 6'b000100, 1'b0, 32'h33, 1'b1, 1'b0, 1'b0);
      chk("bubble_cnt_2", {16'd0, bubble_cnt}, 32'd2);
      // flush beats hold; second flush on empty register does not count
      step("load44", 6'b000000, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0);
      step("flush1", 6'b001100, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      step("flush2", 6'b000000, 1'b1, 32'h78, 1'b1, 1'b0, 1'b0);
      chk("flush_cnt_1", {16'd0, flush_cnt}, 32'd1);
      // illegal stall pattern holds and sets the sticky flag
      step("load55", 6'b000000, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0);
      step("illegal", 6'b001000, 1'b0, 32'h66, 1'b1, 1'b0, 1'b0);
      chk("illegal_data", out_data, 32'h55);
      step("sticky", 6'b000000, 1'b0, 32'h67, 1'b0, 1'b0, 1'b0);
      chk("sticky_err", {31'd0, stall_err}, 32'd1);
      step("clr",    6'b000000, 1'b0, 32'h68, 1'b1, 1'b1, 1'b0);
      // unrelated stall bits are ignored
      step("ignore", 6'b110011, 1'b0, 32'hA5A5, 1'b1, 1'b0, 1'b0);
      // saturation on the 3-bit counter instance, then clear wins over a hold
      for (int i = 0; i < 10; i++) step("sat", 6'b001100, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
      chk("sat_hold3", {29'd0, s_hold_cnt}, 32'd7);
      step("satclr", 6'b001100, 1'b0, 32'h2, 1'b1, 1'b1, 1'b0);
      chk("satclr_hold3", {29'd0, s_hold_cnt}, 32'd0);
      // reset in the middle of a hold
      step("pre",    6'b000000, 1'b0, 32'hC0DE, 1'b1, 1'b0, 1'b0);
      step("midh",   6'b001100, 1'b0, 32'h3, 1'b1, 1'b0, 1'b0);
      step("rsth",   6'b001100, 1'b0, 32'h4, 1'b1, 1'b0, 1'b1);
      // random traffic against the model
      for (int i = 0; i < 60; i++)
         step("rand", 6'($urandom), ($urandom_range(0, 7) == 0), $urandom,
              1'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register; the successor to the fixed-field ID/EX latch. It carries an opaque DATA_W payload plus a valid bit, and reads the shared stall vector at a configurable stage index. It adds flush, bubble/hold accounting with saturating performance counters, and a sticky illegal-stall detector. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 32: payload width in bits (1..256).
- STALL_W, 6: width of the shared stall vector.
- STAGE, 2: index of the upstream stage's stall bit, 0..STALL_W-2. The downstream bit is STAGE+1.
- NOP_VALUE, {DATA_W{1'b0}}: payload loaded on reset, flush or bubble.
- CNT_W, 16: width of each performance counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  shared stall vector; 1 = stage stalled.
- flush  in  1  discard the register contents this cycle.
- in_data  in  DATA_W  payload from the upstream stage.
- in_valid  in  1  upstream payload is a real instruction.
- cnt_clr  in  1  synchronous clear of counters and the error flag.
- out_data  out  DATA_W  registered payload to the downstream stage.
- out_valid  out  1  registered valid.
- hold_cnt  out  CNT_W  saturating count of hold cycles.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.
- flush_cnt  out  CNT_W  saturating count of flushes that killed a valid entry.
- stall_err  out  1  sticky: an illegal stall pattern was seen.

## Operation
Let up = stall[STAGE] and dn = stall[STAGE+1]. Evaluate the following in strict priority order each cycle:
1. rst: out_data=NOP_VALUE, out_valid=0, all counters=0, stall_err=0.
2. flush: out_data=NOP_VALUE, out_valid=0. Flush overrides every stall combination. flush_cnt increments only if out_valid was 1 before the edge.
3. up=1, dn=0 (bubble): out_data=NOP_VALUE, out_valid=0. bubble_cnt increments.
4. up=1, dn=1 (hold): out_data and out_valid are unchanged. hold_cnt increments.
5. up=0, dn=0 (advance): out_data=in_data, out_valid=in_valid.
6. up=0, dn=1 (illegal, since a stage may not run while the one below it is stalled): stall_err is set and sticks. The register still holds, exactly as in case 4, but hold_cnt does not increment.

Counter and flag rules:
- Counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clr, when rst is low, zeroes all three counters and stall_err on the next edge. It does not touch out_data or out_valid.
- If cnt_clr and a counting event occur in the same cycle, the counter ends at 0 (clear wins).
- Stall bits other than STAGE and STAGE+1 are ignored.
- The bubble is always NOP_VALUE regardless of in_valid, and is never reported as valid.

## Timing
- Latency: one cycle from in_data/in_valid to out_data/out_valid in advance mode.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- Counters and stall_err update on the same edge as the data path and are visible the following cycle.
- Reset mid-hold or mid-bubble: the next edge forces the reset values; no pending state survives.
- Release from a hold: the first edge with up=0, dn=0 loads the current in_data. The held value is overwritten, not replayed.
- Multi-cycle stalls: a hold lasting N cycles adds N to hold_cnt. N back-to-back bubble cycles add N to bubble_cnt, and out_valid stays 0 throughout.

## Test plan
- Reset: drive rst=1 with in_data=0xDEADBEEF and stall=0 -> next cycle out_data=0, out_valid=0, all counters 0, stall_err=0.
- Advance then hold: load 0x11 (valid), then hold for 3 cycles with stall=6'b001100 (STAGE=2) -> out_data stays 0x11 and out_valid stays 1, hold_cnt=3. Release with stall=0 and in_data=0x22 -> out_data=0x22.
- Bubble: stall=6'b000100 for 2 cycles with in_data=0x33 -> out_valid=0, out_data=NOP_VALUE, bubble_cnt=2.
- Flush priority: a valid 0x44 is in the register; assert flush together with stall=6'b001100 -> out_valid=0, out_data=NOP_VALUE, flush_cnt=1. A second flush on an empty register -> flush_cnt stays 1.
- Illegal pattern: stall=6'b001000 with 0x55 held -> out_data remains 0x55, stall_err=1 and stays 1 after stall=0. hold_cnt is unchanged. cnt_clr then returns stall_err to 0.
- Saturation: set CNT_W=3 and hold for 10 cycles -> hold_cnt=7. Assert cnt_clr during one more hold cycle -> hold_cnt=0.
